// File: rtl/counter_pkg.sv
// Shared mode constants and the clamp helper for the parametrised up/down counter.
package counter_pkg;

  localparam bit CNT_WRAP = 1'b0;
  localparam bit CNT_SAT  = 1'b1;

  function automatic logic [31:0] clamp_max(input logic [31:0] val, input logic [31:0] lim);
    logic [31:0] res;
    if (val > lim) begin
      res = lim;
    end else begin
      res = val;
    end
    return res;
  endfunction

endpackage

// File: rtl/mod_step_calc.sv
// Next-count arithmetic for one count cycle: wrap or clamp at 0 / MAX_VAL.
// evt flags a wrap, or a clamp that actually moved q onto the bound.
module mod_step_calc
  import counter_pkg::*;
#(
  parameter int          WIDTH    = 4,
  parameter int unsigned MAX_VAL  = 32'((64'd1 << WIDTH) - 64'd1),
  parameter bit          SATURATE = CNT_WRAP
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] step_eff,
  input  logic             up,
  output logic [WIDTH-1:0] next_q,
  output logic             evt
);

  // One extra bit keeps q+step and q+modulus exact even when MAX_VAL = 2**WIDTH-1.
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   MOD_EXT = MAX_EXT + (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MAX_VAL);

  logic [WIDTH:0] q_ext_s;
  logic [WIDTH:0] step_ext_s;
  logic [WIDTH:0] sum_s;

  assign q_ext_s    = {1'b0, q};
  assign step_ext_s = {1'b0, step_eff};
  assign sum_s      = q_ext_s + step_ext_s;

  // Select the in-range, wrapped or clamped result for the current direction.
  always_comb begin
    next_q = q;
    evt    = 1'b0;
    if (up) begin
      if (sum_s > MAX_EXT) begin
        if (SATURATE == CNT_SAT) begin
          next_q = MAX_Q;
          evt    = (q != MAX_Q);
        end else begin
          next_q = WIDTH'(sum_s - MOD_EXT);
          evt    = 1'b1;
        end
      end else begin
        next_q = sum_s[WIDTH-1:0];
        evt    = 1'b0;
      end
    end else begin
      if (step_ext_s > q_ext_s) begin
        if (SATURATE == CNT_SAT) begin
          next_q = '0;
          evt    = (q != '0);
        end else begin
          next_q = WIDTH'(q_ext_s + MOD_EXT - step_ext_s);
          evt    = 1'b1;
        end
      end else begin
        next_q = WIDTH'(q_ext_s - step_ext_s);
        evt    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Parametrised up/down counter with load, hold, programmable step,
// wrap-or-saturate bounds, combinational terminal count and registered overflow pulse.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int          WIDTH    = 4,
  parameter int unsigned MAX_VAL  = 32'((64'd1 << WIDTH) - 64'd1),
  parameter bit          SATURATE = CNT_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             up,
  input  logic             hold,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] q_q, q_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] d_clamp_s;
  logic [WIDTH-1:0] step_eff_s;
  logic [WIDTH-1:0] next_q_s;
  logic             evt_s;

  assign d_clamp_s  = WIDTH'(clamp_max(32'(d), 32'(MAX_VAL)));
  assign step_eff_s = WIDTH'(clamp_max(32'(step), 32'(MAX_VAL)));

  mod_step_calc #(
    .WIDTH    (WIDTH),
    .MAX_VAL  (MAX_VAL),
    .SATURATE (SATURATE)
  ) u_step_calc (
    .q        (q_q),
    .step_eff (step_eff_s),
    .up       (up),
    .next_q   (next_q_s),
    .evt      (evt_s)
  );

  // Load beats hold beats count; only a counting cycle can raise ovf.
  always_comb begin
    q_d   = q_q;
    ovf_d = 1'b0;
    if (load) begin
      q_d   = d_clamp_s;
      ovf_d = 1'b0;
    end else if (hold) begin
      q_d   = q_q;
      ovf_d = 1'b0;
    end else begin
      q_d   = next_q_s;
      ovf_d = evt_s;
    end
  end

  // Count and overflow registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  assign q   = q_q;
  assign ovf = ovf_q;
  assign tc  = up ? (q_q == MAX_Q) : (q_q == '0);

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: three configurations driven in lockstep, checked every
// cycle against an integer model, plus hand-computed expectations for the directed vectors.
module tb_mod_updown_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0, load = 1'b0, hold = 1'b0, up = 1'b1;
  logic [7:0] d = 8'd0, step = 8'd0;
  logic [3:0] q0, q1;
  logic [7:0] q2;
  logic       tc0, tc1, tc2, ovf0, ovf1, ovf2;

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .load(load), .d(d[3:0]), .up(up), .hold(hold),
    .step(step[3:0]), .q(q0), .tc(tc0), .ovf(ovf0));
  mod_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .load(load), .d(d[3:0]), .up(up), .hold(hold),
    .step(step[3:0]), .q(q1), .tc(tc1), .ovf(ovf1));
  mod_updown_counter #(.WIDTH(8), .MAX_VAL(255), .SATURATE(1'b0)) dut2 (
    .clk(clk), .rst(rst), .load(load), .d(d), .up(up), .hold(hold),
    .step(step), .q(q2), .tc(tc2), .ovf(ovf2));

  int n_vec = 0;
  int n_bad = 0;
  bit mvalid = 1'b0;
  int mq[3], movf[3];
  int mmax[3]  = '{9, 9, 255};
  int mmask[3] = '{15, 15, 255};
  bit msat[3]  = '{1'b0, 1'b1, 1'b0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: count is modular arithmetic over [0, MAX_VAL], or clipped to the bounds.
  task automatic model_update(input int k);
    int m, dv, se, n, lim;
    m  = mmax[k];
    dv = int'(d) & mmask[k];
    se = int'(step) & mmask[k];
    if (rst) begin
      mq[k] = 0; movf[k] = 0;
    end else if (load) begin
      mq[k] = (dv > m) ? m : dv; movf[k] = 0;
    end else if (hold) begin
      movf[k] = 0;
    end else begin
      if (se > m) se = m;
      n = up ? mq[k] + se : mq[k] - se;
      if (n >= 0 && n <= m) begin
        mq[k] = n; movf[k] = 0;
      end else if (msat[k]) begin
        lim = up ? m : 0;
        movf[k] = (mq[k] != lim) ? 1 : 0;
        mq[k] = lim;
      end else begin
        mq[k] = ((n % (m + 1)) + (m + 1)) % (m + 1);
        movf[k] = 1;
      end
    end
  endtask

  function automatic int model_tc(input int k);
    return ((up && mq[k] == mmax[k]) || (!up && mq[k] == 0)) ? 1 : 0;
  endfunction

  // Every-cycle comparison of all three counters against the model.
  always @(negedge clk) begin
    if (mvalid) begin
      chk("q0", 32'(q0), 32'(mq[0]));   chk("ovf0", 32'(ovf0), 32'(movf[0]));
      chk("tc0", 32'(tc0), 32'(model_tc(0)));
      chk("q1", 32'(q1), 32'(mq[1]));   chk("ovf1", 32'(ovf1), 32'(movf[1]));
      chk("tc1", 32'(tc1), 32'(model_tc(1)));
      chk("q2", 32'(q2), 32'(mq[2]));   chk("ovf2", 32'(ovf2), 32'(movf[2]));
      chk("tc2", 32'(tc2), 32'(model_tc(2)));
    end
  end

  task automatic vec(input logic r, input logic l, input logic h, input logic u,
                     input logic [7:0] dd, input logic [7:0] ss);
    rst = r; load = l; hold = h; up = u; d = dd; step = ss;
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_update(k);
    if (r) mvalid = 1'b1;
    @(negedge clk);
    #1;
  endtask

  int exp_cnt[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int exp_ld[5]   = '{0, 3, 6, 9, 2};
  int ovf_ld[5]   = '{1, 0, 0, 0, 1};
  int exp_dn[3]   = '{9, 7, 5};

  initial begin
    // reset
    vec(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0);
    chk("rst_q0", 32'(q0), 32'd0);  chk("rst_ovf0", 32'(ovf0), 32'd0);
    chk("rst_q2", 32'(q2), 32'd0);
    // count up by 1 through the wrap
    for (int i = 0; i < 12; i++) begin
      vec(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd1);
      chk("cnt_q0", 32'(q0), 32'(exp_cnt[i]));
      chk("cnt_ovf0", 32'(ovf0), (i == 9) ? 32'd1 : 32'd0);
      chk("cnt_tc0", 32'(tc0), (i == 8) ? 32'd1 : 32'd0);
    end
    // load then step 3
    vec(1'b0, 1'b1, 1'b0, 1'b1, 8'd7, 8'd3);
    chk("ld_q0", 32'(q0), 32'd7);
    for (int i = 0; i < 5; i++) begin
      vec(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd3);
      chk("step3_q0", 32'(q0), 32'(exp_ld[i]));
      chk("step3_ovf0", 32'(ovf0), 32'(ovf_ld[i]));
    end
    vec(1'b0, 1'b1, 1'b0, 1'b1, 8'd14, 8'd3);
    chk("ldclamp_q0", 32'(q0), 32'd9);  chk("ldclamp_ovf0", 32'(ovf0), 32'd0);
    // hold and priority
    vec(1'b0, 1'b1, 1'b0, 1'b1, 8'd5, 8'd1);
    for (int i = 0; i < 3; i++) begin
      vec(1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 8'd1);
      chk("hold_q0", 32'(q0), 32'd5);
    end
    vec(1'b0, 1'b1, 1'b1, 1'b1, 8'd2, 8'd1);
    chk("ld_over_hold", 32'(q0), 32'd2);
    vec(1'b1, 1'b1, 1'b0, 1'b1, 8'd6, 8'd1);
    chk("rst_over_ld", 32'(q0), 32'd0);
    // down wrap
    vec(1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd2);
    for (int i = 0; i < 3; i++) begin
      vec(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd2);
      chk("down_q0", 32'(q0), 32'(exp_dn[i]));
      chk("down_ovf0", 32'(ovf0), (i == 0) ? 32'd1 : 32'd0);
    end
    // tc follows up without a clock edge
    vec(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd2);
    up = 1'b0; #1;
    chk("tc_down_at0", 32'(tc0), 32'd1);
    up = 1'b1; #1;
    chk("tc_up_at0", 32'(tc0), 32'd0);
    up = 1'b0; #1;
    chk("tc_down_again", 32'(tc0), 32'd1);
    // saturating instance
    vec(1'b0, 1'b1, 1'b0, 1'b1, 8'd8, 8'd3);
    vec(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd3);
    chk("sat_up_q1", 32'(q1), 32'd9);  chk("sat_up_ovf1", 32'(ovf1), 32'd1);
    vec(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd3);
    chk("sat_up2_q1", 32'(q1), 32'd9); chk("sat_up2_ovf1", 32'(ovf1), 32'd0);
    vec(1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 8'd4);
    vec(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd4);
    chk("sat_dn_q1", 32'(q1), 32'd0);  chk("sat_dn_ovf1", 32'(ovf1), 32'd1);
    vec(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd4);
    chk("sat_dn2_q1", 32'(q1), 32'd0); chk("sat_dn2_ovf1", 32'(ovf1), 32'd0);
    // full-range 8-bit instance
    vec(1'b0, 1'b1, 1'b0, 1'b1, 8'd250, 8'd10);
    chk("ld250_q2", 32'(q2), 32'd250);
    vec(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd10);
    chk("wrap8_q2", 32'(q2), 32'd4);   chk("wrap8_ovf2", 32'(ovf2), 32'd1);
    vec(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0);
    chk("step0_q2", 32'(q2), 32'd4);   chk("step0_ovf2", 32'(ovf2), 32'd0);
    vec(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd255);
    chk("step255_q2", 32'(q2), 32'd3); chk("step255_ovf2", 32'(ovf2), 32'd1);
    // mixed sequence, checked by the model only
    for (int i = 0; i < 80; i++) begin
      vec(($urandom_range(0, 24) == 0), ($urandom_range(0, 6) == 0),
          ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
          8'($urandom_range(0, 255)),
          ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255)));
    end
    mvalid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
- Parametrised up/down counter; next generation of the team's 4-bit load/up/hold counter.
- Adds configurable width, modulus (MAX_VAL), programmable step, wrap-or-saturate mode, terminal-count flag and registered overflow pulse.
- Used as a generic timebase/index generator in datapath and FSM blocks; single clock domain.

Parameters:
- WIDTH, 4, counter width in bits (2..32).
- MAX_VAL, 2**WIDTH-1, highest count value; the modulus is MAX_VAL+1; must satisfy 1 <= MAX_VAL <= 2**WIDTH-1.
- SATURATE, 0, 0 = wrap at the bounds; 1 = clamp at the bounds.

Ports:
- clk, in, 1, rising-edge clock.
- rst, in, 1, synchronous active-high reset.
- load, in, 1, load d into q.
- d, in, WIDTH, load value.
- up, in, 1, 1 = count up; 0 = count down.
- hold, in, 1, freeze q.
- step, in, WIDTH, increment magnitude per count cycle.
- q, out, WIDTH, current count.
- tc, out, 1, terminal count (combinational from q and up).
- ovf, out, 1, one-cycle registered pulse after a wrap or clamp event.

Behaviour:
- All state updates on the rising edge of clk. One clock; reset is synchronous and active-high.
- Priority, highest first: rst > load > hold > count.
- rst: q=0, ovf=0 on the next edge. rst overrides every other input in the same cycle.
- load: q = min(d, MAX_VAL); ovf=0. Load does not raise ovf, even when d is clamped.
- hold (with load=0): q unchanged; ovf=0.
- count (no rst/load/hold): q changes every cycle by step_eff = min(step, MAX_VAL).
- step_eff=0: q unchanged, ovf=0.
- Arithmetic uses WIDTH+1 bits internally; no intermediate truncation.
- Up, q+step_eff <= MAX_VAL: q = q+step_eff, ovf=0.
- Up, q+step_eff > MAX_VAL, SATURATE=0: q = q+step_eff-(MAX_VAL+1), ovf=1.
- Up, q+step_eff > MAX_VAL, SATURATE=1: q = MAX_VAL. ovf=1 only if q was below MAX_VAL before the edge; if q was already MAX_VAL, q stays and ovf=0.
- Down, step_eff <= q: q = q-step_eff, ovf=0.
- Down, step_eff > q, SATURATE=0: q = q+(MAX_VAL+1)-step_eff, ovf=1.
- Down, step_eff > q, SATURATE=1: q = 0. ovf=1 only if q was nonzero before the edge.
- ovf is high for exactly the one cycle following the triggering edge. It deasserts on the next edge unless a new event occurs.
- tc = (up && q==MAX_VAL) || (!up && q==0). It follows up combinationally, with no latency.
- Changing up or step mid-sequence takes effect on the next edge; no pipeline and no extra latency.
- q never exceeds MAX_VAL under any input sequence after reset.
- Before the first reset, q is X. The bench must apply rst first.

Decomposition:
- Package counter_pkg holds mode constants CNT_WRAP=0 and CNT_SAT=1, plus a clamp function used for both d and step.
- One combinational sub-module, mod_step_calc, takes q, step_eff, up and the parameters, and outputs next_q and evt.
- The top-level module holds the q/ovf registers and the priority mux.

Test Plan (WIDTH=4, MAX_VAL=9 unless stated):
- Reset then count: rst=1 for 1 cycle, then up=1, step=1 for 12 cycles -> q 0..9,0,1,2; ovf=1 only in the cycle after 9->0; tc=1 while q=9.
- Load and step: load d=7, then up, step=3 -> q 7,0,3,6,9,2; ovf pulses after 7->0 and 9->2. Load d=14 -> q=9, ovf=0.
- Hold and priority: q=5, hold=1 for 3 cycles -> q stays 5. load=1 with d=2 and hold=1 -> q=2. rst=1 with load=1 -> q=0.
- Down wrap: q=1, up=0, step=2 -> q 9,7,5; ovf=1 after 1->9; tc=1 while q=0, and tc follows an up toggle in the same cycle.
- Saturate (SATURATE=1): q=8, up, step=3 -> q 9 (ovf=1), 9 (ovf=0). Then down, step=4 from q=2 -> q=0 (ovf=1), 0 (ovf=0).
- Full-range/step edge cases (WIDTH=8, MAX_VAL=255): q=250, step=10 -> q=4, ovf=1. step=0 -> q unchanged, ovf=0. step=300 is not representable; step=255 gives step_eff=255, so q=4 -> q=3.
